decode_stage_pipe: RTL and testbench

- Parametrised Y86-64 decode stage sitting between the fetch and execute pipeline registers.
- Decodes icode to register-file read addresses (srcA/srcB) and destination tags (dstE/dstM), reads the register file combinationally, and resolves data hazards through a generic prioritised forwarding network.
- Detects load-use hazards and holds results in the D→E pipeline register under a valid/ready handshake, with stall, bubble and flush.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/decode_fwd_mux.sv | 32 +++
 rtl/decode_stage_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes, special register ids and the
// control fields carried in the decode-to-execute pipeline register.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Special register ids (for the default 4-bit register id width)
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    // Control fields of the E register
    typedef struct packed {
        logic [3:0] icode;
        logic [3:0] ifun;
    } dec_ctl_t;

    // Instructions whose dstM is written from memory
    function automatic logic is_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/decode_fwd_mux.sv
// Priority forwarding mux: the lowest-index valid channel whose destination
// matches the source register supplies the operand, else register-file data.
// An all-ones source (no register) never matches.
module decode_fwd_mux #(
    parameter int unsigned NUM_FWD = 5,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned REG_AW  = 4
) (
    input  logic [REG_AW-1:0]         src_i,
    input  logic [DATA_W-1:0]         rf_data_i,
    input  logic [NUM_FWD-1:0]        fwd_vld_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_dst_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_val_i,
    output logic [DATA_W-1:0]         val_o
);

    logic hit;

    // Scan channels from highest priority; first match wins
    always_comb begin
        val_o = rf_data_i;
        hit   = 1'b0;
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!hit && (src_i != {REG_AW{1'b1}}) && fwd_vld_i[i] &&
                (fwd_dst_i[i*REG_AW +: REG_AW] == src_i)) begin
                val_o = fwd_val_i[i*DATA_W +: DATA_W];
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Y86-64 decode stage: register-id decode, register-file read, prioritised
// forwarding, load-use stall and the D->E pipeline register with valid/ready,
// bubble and flush.
// Optional: define DECODE_ILLEGAL_TRAP_EN to flag icodes above POPQ on
// out_ins_err; otherwise out_ins_err is tied low.
module decode_stage_pipe
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned NUM_FWD = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_icode,
    input  logic [3:0]                in_ifun,
    input  logic [REG_AW-1:0]         in_rA,
    input  logic [REG_AW-1:0]         in_rB,
    input  logic [DATA_W-1:0]         in_valC,
    input  logic [DATA_W-1:0]         in_valP,
    input  logic                      flush,
    output logic [REG_AW-1:0]         rf_raddr_a,
    output logic [REG_AW-1:0]         rf_raddr_b,
    input  logic [DATA_W-1:0]         rf_rdata_a,
    input  logic [DATA_W-1:0]         rf_rdata_b,
    input  logic [NUM_FWD-1:0]        fwd_vld,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_dst,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_val,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3:0]                out_icode,
    output logic [3:0]                out_ifun,
    output logic [DATA_W-1:0]         out_valA,
    output logic [DATA_W-1:0]         out_valB,
    output logic [DATA_W-1:0]         out_valC,
    output logic [REG_AW-1:0]         out_dstE,
    output logic [REG_AW-1:0]         out_dstM,
    output logic [REG_AW-1:0]         out_srcA,
    output logic [REG_AW-1:0]         out_srcB,
    output logic                      out_ins_err
);

    localparam logic [REG_AW-1:0] RegNone = {REG_AW{1'b1}};
    localparam logic [REG_AW-1:0] RegSp   = REG_AW'(RSP);

    logic [REG_AW-1:0] src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] fwd_a, fwd_b, val_a;
    logic              hazard, adv, accept, ins_err;

    logic              valid_d, valid_q;
    dec_ctl_t          ctl_d, ctl_q;
    logic [DATA_W-1:0] val_a_d, val_a_q, val_b_d, val_b_q, val_c_d, val_c_q;
    logic [REG_AW-1:0] dst_e_d, dst_e_q, dst_m_d, dst_m_q;
    logic [REG_AW-1:0] src_a_d, src_a_q, src_b_d, src_b_q;

    // Register-id decode from icode; illegal icodes fall to RNONE on all tags
    always_comb begin
        src_a = RegNone;
        src_b = RegNone;
        dst_e = RegNone;
        dst_m = RegNone;
        case (in_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = in_rA;
            I_RET, I_POPQ:                     src_a = RegSp;
            default:                           src_a = RegNone;
        endcase
        case (in_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:         src_b = in_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:    src_b = RegSp;
            default:                           src_b = RegNone;
        endcase
        case (in_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:         dst_e = in_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:    dst_e = RegSp;
            default:                           dst_e = RegNone;
        endcase
        case (in_icode)
            I_MRMOVQ, I_POPQ:                  dst_m = in_rA;
            default:                           dst_m = RegNone;
        endcase
    end

    assign rf_raddr_a = src_a;
    assign rf_raddr_b = src_b;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign ins_err = (in_icode > I_POPQ);
`else
    assign ins_err = 1'b0;
`endif

    decode_fwd_mux #(
        .NUM_FWD (NUM_FWD),
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW)
    ) u_fwd_a (
        .src_i     (src_a),
        .rf_data_i (rf_rdata_a),
        .fwd_vld_i (fwd_vld),
        .fwd_dst_i (fwd_dst),
        .fwd_val_i (fwd_val),
        .val_o     (fwd_a)
    );

    decode_fwd_mux #(
        .NUM_FWD (NUM_FWD),
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW)
    ) u_fwd_b (
        .src_i     (src_b),
        .rf_data_i (rf_rdata_b),
        .fwd_vld_i (fwd_vld),
        .fwd_dst_i (fwd_dst),
        .fwd_val_i (fwd_val),
        .val_o     (fwd_b)
    );

    // jXX and call carry valP in valA; everything else takes the forwarded value
    always_comb begin
        val_a = fwd_a;
        if ((in_icode == I_JXX) || (in_icode == I_CALL)) begin
            val_a = in_valP;
        end
    end

    // Load in E whose result is needed now: one bubble, then forwarding covers it
    always_comb begin
        hazard = valid_q && is_load(ctl_q.icode) && (dst_m_q != RegNone) &&
                 ((dst_m_q == src_a) || (dst_m_q == src_b));
        adv    = !valid_q || out_ready;
        accept = adv && in_valid && !hazard && !flush;
    end

    assign in_ready = adv && !hazard && !flush;

    // E-register next state: flush, capture, bubble or hold
    always_comb begin
        valid_d = valid_q;
        ctl_d   = ctl_q;
        val_a_d = val_a_q;
        val_b_d = val_b_q;
        val_c_d = val_c_q;
        dst_e_d = dst_e_q;
        dst_m_d = dst_m_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            ctl_d.icode = in_icode;
            ctl_d.ifun  = in_ifun;
            val_a_d     = val_a;
            val_b_d     = fwd_b;
            val_c_d     = in_valC;
            dst_e_d     = dst_e;
            dst_m_d     = dst_m;
            src_a_d     = src_a;
            src_b_d     = src_b;
        end else if (adv) begin
            valid_d = 1'b0;
        end
    end

    // E-register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
            val_a_q <= '0;
            val_b_q <= '0;
            val_c_q <= '0;
            dst_e_q <= RegNone;
            dst_m_q <= RegNone;
            src_a_q <= RegNone;
            src_b_q <= RegNone;
        end else begin
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
            val_a_q <= val_a_d;
            val_b_q <= val_b_d;
            val_c_q <= val_c_d;
            dst_e_q <= dst_e_d;
            dst_m_q <= dst_m_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic ins_err_d, ins_err_q;

    // Illegal-instruction flag travels with the captured instruction
    always_comb begin
        ins_err_d = ins_err_q;
        if (!flush && accept) begin
            ins_err_d = ins_err;
        end
    end

    // Illegal-instruction flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_err_q <= 1'b0;
        end else begin
            ins_err_q <= ins_err_d;
        end
    end

    assign out_ins_err = ins_err_q;
`else
    assign out_ins_err = ins_err;
`endif

    assign out_valid = valid_q;
    assign out_icode = ctl_q.icode;
    assign out_ifun  = ctl_q.ifun;
    assign out_valA  = val_a_q;
    assign out_valB  = val_b_q;
    assign out_valC  = val_c_q;
    assign out_dstE  = dst_e_q;
    assign out_dstM  = dst_m_q;
    assign out_srcA  = src_a_q;
    assign out_srcB  = src_b_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: decode, forwarding priority, load-use
// bubble, backpressure, call/ret/push/pop, flush, mid-stall reset, illegal icode.
module tb_decode_stage_pipe;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned REG_AW  = 4;
    localparam int unsigned NUM_FWD = 5;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid, in_ready;
    logic [3:0]                in_icode, in_ifun;
    logic [REG_AW-1:0]         in_rA, in_rB;
    logic [DATA_W-1:0]         in_valC, in_valP;
    logic                      flush;
    logic [REG_AW-1:0]         rf_raddr_a, rf_raddr_b;
    logic [DATA_W-1:0]         rf_rdata_a, rf_rdata_b;
    logic [NUM_FWD-1:0]        fwd_vld;
    logic [NUM_FWD*REG_AW-1:0] fwd_dst;
    logic [NUM_FWD*DATA_W-1:0] fwd_val;
    logic                      out_valid, out_ready;
    logic [3:0]                out_icode, out_ifun;
    logic [DATA_W-1:0]         out_valA, out_valB, out_valC;
    logic [REG_AW-1:0]         out_dstE, out_dstM, out_srcA, out_srcB;
    logic                      out_ins_err;

    int checks   = 0;
    int failures = 0;

    decode_stage_pipe #(
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW),
        .NUM_FWD (NUM_FWD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_icode    (in_icode),
        .in_ifun     (in_ifun),
        .in_rA       (in_rA),
        .in_rB       (in_rB),
        .in_valC     (in_valC),
        .in_valP     (in_valP),
        .flush       (flush),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_rdata_a  (rf_rdata_a),
        .rf_rdata_b  (rf_rdata_b),
        .fwd_vld     (fwd_vld),
        .fwd_dst     (fwd_dst),
        .fwd_val     (fwd_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_icode   (out_icode),
        .out_ifun    (out_ifun),
        .out_valA    (out_valA),
        .out_valB    (out_valB),
        .out_valC    (out_valC),
        .out_dstE    (out_dstE),
        .out_dstM    (out_dstM),
        .out_srcA    (out_srcA),
        .out_srcB    (out_srcB),
        .out_ins_err (out_ins_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs checked after that
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_fwd();
        fwd_vld = '0;
        fwd_dst = '0;
        fwd_val = '0;
    endtask

    task automatic set_fwd(input int ch, input logic [REG_AW-1:0] dst,
                           input logic [DATA_W-1:0] val);
        fwd_vld[ch]                  = 1'b1;
        fwd_dst[ch*REG_AW +: REG_AW] = dst;
        fwd_val[ch*DATA_W +: DATA_W] = val;
    endtask

    task automatic present(input logic [3:0] icode, input logic [3:0] rA,
                           input logic [3:0] rB, input logic [63:0] valC,
                           input logic [63:0] valP);
        in_valid = 1'b1;
        in_icode = icode;
        in_ifun  = 4'h0;
        in_rA    = rA;
        in_rB    = rB;
        in_valC  = valC;
        in_valP  = valP;
    endtask

    logic exp_err;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_icode = '0; in_ifun = '0; in_rA = '0; in_rB = '0;
        in_valC = '0; in_valP = '0; flush = 1'b0; rf_rdata_a = '0; rf_rdata_b = '0;
        out_ready = 1'b1;
        clear_fwd();
        #12;
        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_dstE", out_dstE, 4'hF);
        check("rst_dstM", out_dstM, 4'hF);
        check("rst_srcA", out_srcA, 4'hF);
        check("rst_srcB", out_srcB, 4'hF);
        check("rst_valA", out_valA, 0);
        check("rst_icode", out_icode, 0);
        check("rst_err", out_ins_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // OPq rA=2 rB=3: channel 0 beats channel 3 on the same register
        present(4'h6, 4'h2, 4'h3, 64'h0, 64'h0);
        rf_rdata_a = 64'h5;
        rf_rdata_b = 64'h7;
        set_fwd(0, 4'h2, 64'h11);
        set_fwd(3, 4'h2, 64'h22);
        settle();
        check("opq_raddr_a", rf_raddr_a, 4'h2);
        check("opq_raddr_b", rf_raddr_b, 4'h3);
        check("opq_in_ready", in_ready, 1);
        check("opq_pre_valid", out_valid, 0);
        tick();
        check("opq_valid", out_valid, 1);
        check("opq_valA", out_valA, 64'h11);
        check("opq_valB", out_valB, 64'h7);
        check("opq_dstE", out_dstE, 4'h3);
        check("opq_dstM", out_dstM, 4'hF);
        check("opq_icode", out_icode, 4'h6);

        // rrmovq rA=2 rB=5: only channel 3 valid; srcB none gives rf data
        clear_fwd();
        present(4'h2, 4'h2, 4'h5, 64'h0, 64'h0);
        set_fwd(3, 4'h2, 64'h22);
        set_fwd(1, 4'hF, 64'hBAD);
        tick();
        check("rr_valA", out_valA, 64'h22);
        check("rr_valB", out_valB, 64'h7);
        check("rr_srcB", out_srcB, 4'hF);
        check("rr_dstE", out_dstE, 4'h5);

        // mrmovq rA=1 rB=6, then dependent OPq rA=1 rB=3
        clear_fwd();
        rf_rdata_b = 64'h100;
        present(4'h5, 4'h1, 4'h6, 64'h8, 64'h0);
        tick();
        check("ld_dstM", out_dstM, 4'h1);
        check("ld_dstE", out_dstE, 4'hF);
        check("ld_valB", out_valB, 64'h100);
        check("ld_valC", out_valC, 64'h8);
        present(4'h6, 4'h1, 4'h3, 64'h0, 64'h0);
        rf_rdata_b = 64'h7;
        settle();
        check("lu_in_ready", in_ready, 0);
        tick();
        check("lu_bubble", out_valid, 0);
        set_fwd(0, 4'h1, 64'h55);
        settle();
        check("lu_ready_again", in_ready, 1);
        tick();
        check("lu_valid", out_valid, 1);
        check("lu_valA", out_valA, 64'h55);
        check("lu_icode", out_icode, 4'h6);

        // Backpressure for three cycles with irmovq waiting
        clear_fwd();
        out_ready = 1'b0;
        present(4'h3, 4'hF, 4'h7, 64'h99, 64'h0);
        settle();
        check("bp_in_ready0", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_icode", out_icode, 4'h6);
            check("bp_hold_valA", out_valA, 64'h55);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        settle();
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_icode", out_icode, 4'h3);
        check("bp_valC", out_valC, 64'h99);
        check("bp_dstE", out_dstE, 4'h7);
        check("bp_srcA", out_srcA, 4'hF);

        // call: valA is valP; stack pointer on srcB and dstE
        rf_rdata_b = 64'h1000;
        present(4'h8, 4'hF, 4'hF, 64'h200, 64'h40);
        tick();
        check("call_valA", out_valA, 64'h40);
        check("call_valB", out_valB, 64'h1000);
        check("call_srcB", out_srcB, 4'h4);
        check("call_dstE", out_dstE, 4'h4);
        check("call_srcA", out_srcA, 4'hF);

        // ret with rsp forwarded on channel 2
        rf_rdata_a = 64'hA0;
        rf_rdata_b = 64'hB0;
        set_fwd(2, 4'h4, 64'h77);
        present(4'h9, 4'hF, 4'hF, 64'h0, 64'h0);
        tick();
        check("ret_srcA", out_srcA, 4'h4);
        check("ret_srcB", out_srcB, 4'h4);
        check("ret_valA", out_valA, 64'h77);
        check("ret_valB", out_valB, 64'h77);
        clear_fwd();

        // popq rA=5
        present(4'hB, 4'h5, 4'hF, 64'h0, 64'h0);
        tick();
        check("pop_dstM", out_dstM, 4'h5);
        check("pop_dstE", out_dstE, 4'h4);
        check("pop_srcA", out_srcA, 4'h4);

        // jXX: valP in valA, no tags
        present(4'h7, 4'hF, 4'hF, 64'h0, 64'h30);
        tick();
        check("jxx_valA", out_valA, 64'h30);
        check("jxx_dstE", out_dstE, 4'hF);

        // Flush with valid input drops it
        present(4'h6, 4'h2, 4'h3, 64'h0, 64'h0);
        flush = 1'b1;
        settle();
        check("fl_in_ready", in_ready, 0);
        tick();
        check("fl_valid", out_valid, 0);
        flush = 1'b0;

        // Reset while an instruction is held under backpressure
        present(4'h5, 4'h1, 4'h6, 64'h8, 64'h0);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        check("rs_held", out_valid, 1);
        rst_n = 1'b0;
        settle();
        check("rs_valid", out_valid, 0);
        check("rs_dstM", out_dstM, 4'hF);
        check("rs_srcB", out_srcB, 4'hF);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Illegal icode 0xC
`ifdef DECODE_ILLEGAL_TRAP_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        present(4'hC, 4'h1, 4'h2, 64'h0, 64'h0);
        tick();
        in_valid = 1'b0;
        check("ill_valid", out_valid, 1);
        check("ill_icode", out_icode, 4'hC);
        check("ill_err", out_ins_err, exp_err);
        check("ill_srcA", out_srcA, 4'hF);
        check("ill_srcB", out_srcB, 4'hF);
        check("ill_dstE", out_dstE, 4'hF);
        check("ill_dstM", out_dstM, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
